// File: rtl/mic1_alu_pkg.sv
// Shared types and ALU control encodings for the MIC-1 ALU arbiter.
// Control word layout is {F0,F1,ENA,ENB,INVA,INC}.
package mic1_alu_pkg;

    localparam int ALU_CTRL_W = 6;

    typedef enum logic [3:0] {
        OP_A         = 4'd0,
        OP_B         = 4'd1,
        OP_NOT_A     = 4'd2,
        OP_NOT_B     = 4'd3,
        OP_ADD       = 4'd4,
        OP_ADD_INC   = 4'd5,
        OP_INC_A     = 4'd6,
        OP_INC_B     = 4'd7,
        OP_B_SUB_A   = 4'd8,
        OP_DEC_B     = 4'd9,
        OP_NEG_A     = 4'd10,
        OP_AND       = 4'd11,
        OP_OR        = 4'd12,
        OP_ZERO      = 4'd13,
        OP_ONE       = 4'd14,
        OP_MINUS_ONE = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_SLL8 = 2'd1,
        SH_SRA1 = 2'd2,
        SH_RSVD = 2'd3
    } shift_e;

    localparam logic [ALU_CTRL_W-1:0] CTRL_A         = 6'b011000;
    localparam logic [ALU_CTRL_W-1:0] CTRL_B         = 6'b010100;
    localparam logic [ALU_CTRL_W-1:0] CTRL_NOT_A     = 6'b011010;
    localparam logic [ALU_CTRL_W-1:0] CTRL_NOT_B     = 6'b101100;
    localparam logic [ALU_CTRL_W-1:0] CTRL_ADD       = 6'b111100;
    localparam logic [ALU_CTRL_W-1:0] CTRL_ADD_INC   = 6'b111101;
    localparam logic [ALU_CTRL_W-1:0] CTRL_INC_A     = 6'b111001;
    localparam logic [ALU_CTRL_W-1:0] CTRL_INC_B     = 6'b110101;
    localparam logic [ALU_CTRL_W-1:0] CTRL_B_SUB_A   = 6'b111111;
    localparam logic [ALU_CTRL_W-1:0] CTRL_DEC_B     = 6'b110110;
    localparam logic [ALU_CTRL_W-1:0] CTRL_NEG_A     = 6'b111011;
    localparam logic [ALU_CTRL_W-1:0] CTRL_AND       = 6'b001100;
    localparam logic [ALU_CTRL_W-1:0] CTRL_OR        = 6'b011100;
    localparam logic [ALU_CTRL_W-1:0] CTRL_ZERO      = 6'b010000;
    localparam logic [ALU_CTRL_W-1:0] CTRL_ONE       = 6'b110001;
    localparam logic [ALU_CTRL_W-1:0] CTRL_MINUS_ONE = 6'b110010;

    function automatic logic [ALU_CTRL_W-1:0] op2ctrl(input alu_op_e op);
        logic [ALU_CTRL_W-1:0] ctrl;
        case (op)
            OP_A:         ctrl = CTRL_A;
            OP_B:         ctrl = CTRL_B;
            OP_NOT_A:     ctrl = CTRL_NOT_A;
            OP_NOT_B:     ctrl = CTRL_NOT_B;
            OP_ADD:       ctrl = CTRL_ADD;
            OP_ADD_INC:   ctrl = CTRL_ADD_INC;
            OP_INC_A:     ctrl = CTRL_INC_A;
            OP_INC_B:     ctrl = CTRL_INC_B;
            OP_B_SUB_A:   ctrl = CTRL_B_SUB_A;
            OP_DEC_B:     ctrl = CTRL_DEC_B;
            OP_NEG_A:     ctrl = CTRL_NEG_A;
            OP_AND:       ctrl = CTRL_AND;
            OP_OR:        ctrl = CTRL_OR;
            OP_ZERO:      ctrl = CTRL_ZERO;
            OP_ONE:       ctrl = CTRL_ONE;
            OP_MINUS_ONE: ctrl = CTRL_MINUS_ONE;
            default:      ctrl = CTRL_ZERO;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mic1_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins.
// Produces a one-hot grant, its index, and an any-grant flag.
module mic1_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any
);

    // Two ordered passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = ID_W'(j);
                o_any       = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (j < int'(i_ptr))) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = ID_W'(j);
                o_any       = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/mic1_alu_arbiter.sv
// Shares one combinational MIC-1 ALU among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Optional result shifter compiled in with MIC1_ALU_SHIFTER_EN.
module mic1_alu_arbiter
    import mic1_alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*4-1:0]      req_op,
    input  logic [NUM_REQ*2-1:0]      req_sh,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_z,
    output logic                      rsp_n,
    output logic [ALU_CTRL_W-1:0]     alu_ctrl,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_z,
    input  logic                      alu_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_gid;
    logic [ALU_CTRL_W-1:0] r_alu_ctrl;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [DATA_W-1:0]     r_rsp_data;
    logic                  r_rsp_z;
    logic                  r_rsp_n;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_gidx;
    logic [ID_W-1:0]       w_ptr_next;
    logic                  w_any;
    logic                  w_accept;
    logic [3:0]            w_sel_op;
    logic [1:0]            w_sel_sh;
    logic [DATA_W-1:0]     w_sel_a;
    logic [DATA_W-1:0]     w_sel_b;
    logic [DATA_W-1:0]     w_result;

`ifdef MIC1_ALU_SHIFTER_EN
    logic [1:0]            r_sh;
`endif

    mic1_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign w_accept  = (r_state == ST_IDLE) && w_any;

    // Select the granted requester's fields via the one-hot grant.
    always_comb begin
        w_sel_op = 4'd0;
        w_sel_sh = 2'd0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_op = req_op[4*i +: 4];
                w_sel_sh = req_sh[2*i +: 2];
                w_sel_a  = req_a[DATA_W*i +: DATA_W];
                w_sel_b  = req_b[DATA_W*i +: DATA_W];
            end else begin
                w_sel_op = w_sel_op;
            end
        end
    end

    // Round-robin pointer advances past the winner, wrapping at NUM_REQ.
    always_comb begin
        if (w_gidx == ID_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_gidx + ID_W'(1);
        end
    end

`ifdef MIC1_ALU_SHIFTER_EN
    // Post-ALU shifter; Z/N deliberately still come from the unshifted ALU result.
    always_comb begin
        case (shift_e'(r_sh))
            SH_SLL8: w_result = {alu_out[DATA_W-9:0], 8'h00};
            SH_SRA1: w_result = {alu_out[DATA_W-1], alu_out[DATA_W-1:1]};
            default: w_result = alu_out;
        endcase
    end
`else
    logic w_unused_sh;
    assign w_unused_sh = ^w_sel_sh;
    assign w_result    = alu_out;
`endif

    // Transaction FSM; ALU drive registers hold the op only while in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_alu_ctrl  <= CTRL_ZERO;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_z     <= 1'b0;
            r_rsp_n     <= 1'b0;
`ifdef MIC1_ALU_SHIFTER_EN
            r_sh        <= 2'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_EXEC;
                        r_ptr      <= w_ptr_next;
                        r_gid      <= w_gidx;
                        r_alu_ctrl <= op2ctrl(alu_op_e'(w_sel_op));
                        r_alu_a    <= w_sel_a;
                        r_alu_b    <= w_sel_b;
`ifdef MIC1_ALU_SHIFTER_EN
                        r_sh       <= w_sel_sh;
`endif
                    end
                end
                ST_EXEC: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_gid;
                    r_rsp_data  <= w_result;
                    r_rsp_z     <= alu_z;
                    r_rsp_n     <= alu_n;
                    r_alu_ctrl  <= CTRL_ZERO;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_alu_ctrl  <= CTRL_ZERO;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_z     = r_rsp_z;
    assign rsp_n     = r_rsp_n;
    assign alu_ctrl  = r_alu_ctrl;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;

endmodule

// File: tb/tb_mic1_alu_arbiter.sv
// Self-checking bench for mic1_alu_arbiter: MIC-1 ALU emulation, transaction-level
// reference model, directed cases with literal expectations, then random traffic.
module tb_mic1_alu_arbiter;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int IDW = $clog2(N);
    localparam logic [DW-1:0] SPEC_A = 32'h3AE9F840;
    localparam logic [DW-1:0] SPEC_B = 32'h578AFE71;
    localparam logic [5:0] CTRL_TBL [16] = '{
        6'b011000, 6'b010100, 6'b011010, 6'b101100, 6'b111100, 6'b111101,
        6'b111001, 6'b110101, 6'b111111, 6'b110110, 6'b111011, 6'b001100,
        6'b011100, 6'b010000, 6'b110001, 6'b110010};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready;
    logic [N*4-1:0]  req_op;
    logic [N*2-1:0]  req_sh;
    logic [N*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready, rsp_z, rsp_n;
    logic [IDW-1:0]  rsp_id;
    logic [DW-1:0]   rsp_data;
    logic [5:0]      alu_ctrl;
    logic [DW-1:0]   alu_a, alu_b, alu_out;
    logic            alu_z, alu_n;

    logic            v     [N];
    logic [3:0]      op_q  [N];
    logic [1:0]      sh_q  [N];
    logic [DW-1:0]   a_q   [N];
    logic [DW-1:0]   b_q   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_op[4*i +: 4]      = op_q[i];
            req_sh[2*i +: 2]      = sh_q[i];
            req_a[DW*i +: DW]     = a_q[i];
            req_b[DW*i +: DW]     = b_q[i];
        end
    end

    // MIC-1 ALU emulation driven by the control word {F0,F1,ENA,ENB,INVA,INC}
    logic [DW-1:0] emu_xa, emu_xb;
    always_comb begin
        emu_xa = alu_ctrl[3] ? alu_a : '0;
        emu_xb = alu_ctrl[2] ? alu_b : '0;
        if (alu_ctrl[1]) emu_xa = ~emu_xa;
        case (alu_ctrl[5:4])
            2'b00:   alu_out = emu_xa & emu_xb;
            2'b01:   alu_out = emu_xa | emu_xb;
            2'b10:   alu_out = ~emu_xb;
            default: alu_out = emu_xa + emu_xb + {31'd0, alu_ctrl[0]};
        endcase
        alu_z = (alu_out == '0);
        alu_n = alu_out[DW-1];
    end

    mic1_alu_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sh(req_sh),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_z(rsp_z), .rsp_n(rsp_n),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'd0:    return a;
            4'd1:    return b;
            4'd2:    return ~a;
            4'd3:    return ~b;
            4'd4:    return a + b;
            4'd5:    return a + b + 32'd1;
            4'd6:    return a + 32'd1;
            4'd7:    return b + 32'd1;
            4'd8:    return b - a;
            4'd9:    return b - 32'd1;
            4'd10:   return -a;
            4'd11:   return a & b;
            4'd12:   return a | b;
            4'd13:   return 32'd0;
            4'd14:   return 32'd1;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_shift(input logic [1:0] sh, input logic [DW-1:0] x);
`ifdef MIC1_ALU_SHIFTER_EN
        if (sh == 2'd1) return x << 8;
        if (sh == 2'd2) return $unsigned($signed(x) >>> 1);
        return x;
`else
        if (sh == 2'd3) return x;
        return x;
`endif
    endfunction

    // Reference model: phase 0 = waiting for a request, 1 = computing, 2 = result offered
    int            m_phase = 0;
    int            m_ptr   = 0;
    int            m_id    = 0;
    logic [3:0]    m_op;
    logic [1:0]    m_sh;
    logic [DW-1:0] m_a, m_b, m_data;
    logic          m_z, m_n;
    int            log_id   [$];
    logic [DW-1:0] log_data [$];
    logic          log_z    [$];
    logic          log_n    [$];
    bit            rnd_mode = 1'b0;
    int            clr_g    = -1;

    function automatic logic [DW-1:0] rnd_word(input logic [DW-1:0] spec);
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return spec;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 2) == 0) begin
                v[i]    = 1'b1;
                op_q[i] = 4'($urandom_range(0, 15));
                sh_q[i] = 2'($urandom_range(0, 3));
                a_q[i]  = rnd_word(SPEC_A);
                b_q[i]  = rnd_word(SPEC_B);
            end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_and_step();
        int gnt;
        logic [DW-1:0] r;
        if (!rst_n) begin
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_id", rsp_id, '0);
            chk("rst_rsp_data", rsp_data, '0);
            chk("rst_rsp_zn", {rsp_z, rsp_n}, 2'b00);
            chk("rst_req_ready", req_ready, '0);
            chk("rst_alu_ctrl", alu_ctrl, 6'b010000);
            chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
            m_phase = 0;
            m_ptr   = 0;
            return;
        end
        gnt = -1;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                if (gnt < 0 && v[(m_ptr + k) % N]) gnt = (m_ptr + k) % N;
            end
        end
        chk("req_ready", req_ready, (gnt >= 0) ? (64'd1 << gnt) : 64'd0);
        chk("rsp_valid", rsp_valid, (m_phase == 2));
        if (m_phase == 2) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_z", rsp_z, m_z);
            chk("rsp_n", rsp_n, m_n);
        end
        chk("alu_ctrl", alu_ctrl, (m_phase == 1) ? CTRL_TBL[m_op] : 6'b010000);
        chk("alu_a", alu_a, (m_phase == 1) ? m_a : '0);
        chk("alu_b", alu_b, (m_phase == 1) ? m_b : '0);
        case (m_phase)
            0: if (gnt >= 0) begin
                m_op = op_q[gnt]; m_sh = sh_q[gnt]; m_a = a_q[gnt]; m_b = b_q[gnt];
                m_id = gnt; m_ptr = (gnt + 1) % N; m_phase = 1; clr_g = gnt;
            end
            1: begin
                r       = ref_alu(m_op, m_a, m_b);
                m_data  = ref_shift(m_sh, r);
                m_z     = (r == '0);
                m_n     = r[DW-1];
                m_phase = 2;
            end
            default: if (rsp_ready) begin
                log_id.push_back(m_id); log_data.push_back(m_data);
                log_z.push_back(m_z);   log_n.push_back(m_n);
                m_phase = 0;
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rnd_mode) randomize_inputs();
        #1;
        check_and_step();
        @(posedge clk);
        #1;
        if (clr_g >= 0) begin
            v[clr_g] = 1'b0;
            clr_g    = -1;
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [1:0] sh);
        v[i] = 1'b1; op_q[i] = op; sh_q[i] = sh; a_q[i] = SPEC_A; b_q[i] = SPEC_B;
    endtask

    initial begin
        int lb;
        logic [DW-1:0] exp_d [3];
        logic [3:0]    ops   [3];
        exp_d = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001};
        ops   = '{4'd13, 4'd15, 4'd14};
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; op_q[i] = 4'd0; sh_q[i] = 2'd0; a_q[i] = '0; b_q[i] = '0;
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // Both requesters continuously asking for B-A: grants alternate
        rsp_ready = 1'b1;
        lb = log_id.size();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) if (!v[i]) set_req(i, 4'd8, 2'd0);
            cycle();
        end
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        chk("rr_count", log_id.size(), lb + 4);
        for (int k = 0; k < 4; k++) begin
            if (lb + k < log_id.size()) begin
                chk("rr_id", log_id[lb + k], k % 2);
                chk("rr_data", log_data[lb + k], 32'h1CA10631);
            end
        end

        // req0 A+B: response offered two cycles after the accepting cycle
        set_req(0, 4'd4, 2'd0);
        cycle();
        cycle();
        chk("lat_valid", rsp_valid, 1'b1);
        chk("lat_data", rsp_data, 32'h9274F6B1);
        chk("lat_nz", {rsp_n, rsp_z}, 2'b10);
        chk("lat_id", rsp_id, '0);
        cycle();

        // req1 constant ops
        for (int k = 0; k < 3; k++) begin
            set_req(1, ops[k], 2'd0);
            repeat (3) cycle();
            chk("const_count", log_data.size() > 0, 1'b1);
            if (log_data.size() > 0) begin
                chk("const_data", log_data[$], exp_d[k]);
                chk("const_z", log_z[$], (k == 0));
                chk("const_n", log_n[$], (k == 1));
                chk("const_id", log_id[$], 1);
            end
        end

        // Back-pressure: result held, no second accept
        rsp_ready = 1'b0;
        set_req(0, 4'd4, 2'd0);
        set_req(1, 4'd4, 2'd0);
        repeat (2) cycle();
        lb = log_id.size();
        repeat (5) cycle();
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_data", rsp_data, 32'h9274F6B1);
        chk("hold_ready", req_ready, '0);
        chk("hold_count", log_id.size(), lb);
        rsp_ready = 1'b1;
        repeat (4) cycle();
        chk("drain_count", log_id.size(), lb + 2);

        // Reset asserted during EXEC drops the operation
        set_req(0, 4'd4, 2'd0);
        cycle();
        lb = log_id.size();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_ctrl", alu_ctrl, 6'b010000);
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("midrst_noresp", log_id.size(), lb);

`ifdef MIC1_ALU_SHIFTER_EN
        set_req(0, 4'd4, 2'd1);
        repeat (3) cycle();
        chk("sll8_data", log_data[$], 32'h74F6B100);
        chk("sll8_nz", {log_n[$], log_z[$]}, 2'b10);
        set_req(0, 4'd4, 2'd2);
        repeat (3) cycle();
        chk("sra1_data", log_data[$], 32'hC93A7B58);
        chk("sra1_nz", {log_n[$], log_z[$]}, 2'b10);
`endif

        rnd_mode = 1'b1;
        repeat (600) cycle();
        rnd_mode  = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
